dsp_mac_pipe: RTL and testbench

Parametrised signed multiply-accumulate pipeline, the successor of the fixed 25x18 multiply-add block. Adds configurable operand, accumulator and output widths and a configurable input register depth. Adds four run-time arithmetic modes including a self-accumulator, valid and clock-enable flow control, and a rounded, saturated narrow output. Sits in the HDMI filter datapath as the building element of FIR taps and pixel-weighting stages.

---
 rtl/dsp_pkg.sv | 22 ++
 rtl/dsp_round_sat.sv | 83 ++++++++
 rtl/dsp_mac_pipe.sv | 183 ++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_pkg : shared mode encodings and parameter legality check for the MAC   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dsp_pkg;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_MADD = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_MSUB = 2'd3
  } mode_e;

  function automatic bit widths_ok(input int a_w, input int b_w, input int p_w,
                                   input int in_reg, input int shift, input int out_w);
    return (p_w >= a_w + b_w + 1) && (in_reg >= 1) && (in_reg <= 4) &&
           (shift >= 0) && (shift <= p_w - 2) && (out_w >= 2) && (out_w <= p_w - shift);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_round_sat : registered round-half-up, arithmetic shift and saturation  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dsp_round_sat #(
  parameter int P_W   = 48,
  parameter int SHIFT = 16,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [P_W-1:0]   p,
  output logic                    y_valid,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  localparam logic signed [P_W:0] C_ONE   = {{P_W{1'b0}}, 1'b1};
  localparam logic signed [P_W:0] C_Y_MAX = {{(P_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W:0] C_Y_MIN = ~C_Y_MAX;

  logic signed [P_W:0] rnd;
  logic signed [P_W:0] p_ext;
  logic signed [P_W:0] r;
  logic signed [P_W:0] rs;

  logic signed [OUT_W-1:0] y_q, y_d;
  logic                    ovf_q, ovf_d;
  logic                    y_valid_q, y_valid_d;

  if (SHIFT == 0) begin : g_no_round
    assign rnd = '0;
  end else begin : g_round
    assign rnd = C_ONE <<< (SHIFT - 1);
  end

  // One guard bit keeps the rounding add from wrapping near full scale.
  assign p_ext = {p[P_W-1], p};
  assign r     = p_ext + rnd;
  assign rs    = r >>> SHIFT;

  always_comb begin
    y_d       = y_q;
    ovf_d     = ovf_q;
    y_valid_d = y_valid_q;
    if (ce) begin
      y_valid_d = in_valid;
      if (in_valid) begin
        if (rs > C_Y_MAX) begin
          y_d   = C_Y_MAX[OUT_W-1:0];
          ovf_d = 1'b1;
        end else if (rs < C_Y_MIN) begin
          y_d   = C_Y_MIN[OUT_W-1:0];
          ovf_d = 1'b1;
        end else begin
          y_d   = rs[OUT_W-1:0];
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      ovf_q     <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign ovf     = ovf_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_mac_pipe : signed multiply-accumulate pipeline with rounded output     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_W    = 25,
  parameter int B_W    = 18,
  parameter int P_W    = 48,
  parameter int IN_REG = 2,
  parameter int SHIFT  = 16,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic signed [P_W-1:0]   pci,
  input  logic [1:0]              mode,
  input  logic                    acc_first,
  output logic                    p_valid,
  output logic signed [P_W-1:0]   p,
  output logic                    y_valid,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  localparam int C_M_W = A_W + B_W;

  if (!widths_ok(A_W, B_W, P_W, IN_REG, SHIFT, OUT_W)) begin : g_param_check
    $error("dsp_mac_pipe: illegal width/depth parameter combination");
  end

  // Input register chain
  logic signed [A_W-1:0] a_q     [IN_REG];
  logic signed [A_W-1:0] a_d     [IN_REG];
  logic signed [B_W-1:0] b_q     [IN_REG];
  logic signed [B_W-1:0] b_d     [IN_REG];
  logic signed [P_W-1:0] pci_q   [IN_REG];
  logic signed [P_W-1:0] pci_d   [IN_REG];
  mode_e                 mode_q  [IN_REG];
  mode_e                 mode_d  [IN_REG];
  logic                  first_q [IN_REG];
  logic                  first_d [IN_REG];
  logic                  vld_q   [IN_REG];
  logic                  vld_d   [IN_REG];

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    pci_d   = pci_q;
    mode_d  = mode_q;
    first_d = first_q;
    vld_d   = vld_q;
    if (ce) begin
      a_d[0]     = a;
      b_d[0]     = b;
      pci_d[0]   = pci;
      mode_d[0]  = mode_e'(mode);
      first_d[0] = acc_first;
      vld_d[0]   = in_valid;
      for (int i = 1; i < IN_REG; i++) begin
        a_d[i]     = a_q[i-1];
        b_d[i]     = b_q[i-1];
        pci_d[i]   = pci_q[i-1];
        mode_d[i]  = mode_q[i-1];
        first_d[i] = first_q[i-1];
        vld_d[i]   = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN_REG; i++) begin
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        pci_q[i]   <= '0;
        mode_q[i]  <= MODE_MUL;
        first_q[i] <= 1'b0;
        vld_q[i]   <= 1'b0;
      end
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      pci_q   <= pci_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      vld_q   <= vld_d;
    end
  end

  // Product stage: operands are sign-extended to full width so the low bits are exact
  logic [C_M_W-1:0]      prod;
  logic signed [P_W-1:0] m_q, m_d;
  logic signed [P_W-1:0] mpci_q, mpci_d;
  mode_e                 mmode_q, mmode_d;
  logic                  mfirst_q, mfirst_d;
  logic                  mvld_q, mvld_d;

  assign prod = {{B_W{a_q[IN_REG-1][A_W-1]}}, a_q[IN_REG-1]} *
                {{A_W{b_q[IN_REG-1][B_W-1]}}, b_q[IN_REG-1]};

  always_comb begin
    m_d      = m_q;
    mpci_d   = mpci_q;
    mmode_d  = mmode_q;
    mfirst_d = mfirst_q;
    mvld_d   = mvld_q;
    if (ce) begin
      m_d      = {{(P_W-C_M_W){prod[C_M_W-1]}}, prod};
      mpci_d   = pci_q[IN_REG-1];
      mmode_d  = mode_q[IN_REG-1];
      mfirst_d = first_q[IN_REG-1];
      mvld_d   = vld_q[IN_REG-1];
    end
  end

  // Result stage: p doubles as the accumulator and wraps modulo 2^P_W
  logic signed [P_W-1:0] p_q, p_d;
  logic                  p_valid_q, p_valid_d;

  always_comb begin
    p_d       = p_q;
    p_valid_d = p_valid_q;
    if (ce) begin
      p_valid_d = mvld_q;
      if (mvld_q) begin
        case (mmode_q)
          MODE_MUL:  p_d = m_q;
          MODE_MADD: p_d = mpci_q + m_q;
          MODE_MSUB: p_d = mpci_q - m_q;
          MODE_ACC:  p_d = mfirst_q ? m_q : (p_q + m_q);
          default:   p_d = p_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      mpci_q    <= '0;
      mmode_q   <= MODE_MUL;
      mfirst_q  <= 1'b0;
      mvld_q    <= 1'b0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      mpci_q    <= mpci_d;
      mmode_q   <= mmode_d;
      mfirst_q  <= mfirst_d;
      mvld_q    <= mvld_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p       = p_q;
  assign p_valid = p_valid_q;

  dsp_round_sat #(
    .P_W  (P_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .in_valid(p_valid_q),
    .p       (p_q),
    .y_valid (y_valid),
    .y       (y),
    .ovf     (ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dsp_mac_pipe : directed self-checking bench for dsp_mac_pipe            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dsp_mac_pipe;

  localparam int C_MUL  = 0;
  localparam int C_MADD = 1;
  localparam int C_ACC  = 2;
  localparam int C_MSUB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic acc_first = 1'b0;
  logic signed [24:0] a = '0;
  logic signed [17:0] b = '0;
  logic signed [47:0] pci = '0;
  logic signed [43:0] pci2 = '0;
  logic [1:0] mode = '0;

  logic p_valid, y_valid, ovf;
  logic signed [47:0] p;
  logic signed [15:0] y;
  logic p2_valid, y2_valid, ovf2;
  logic signed [43:0] p2;
  logic signed [15:0] y2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe u_dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .pci(pci),
    .mode(mode), .acc_first(acc_first), .p_valid(p_valid), .p(p),
    .y_valid(y_valid), .y(y), .ovf(ovf)
  );

  dsp_mac_pipe #(.P_W(44)) u_dut44 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .pci(pci2),
    .mode(mode), .acc_first(acc_first), .p_valid(p2_valid), .p(p2),
    .y_valid(y2_valid), .y(y2), .ovf(ovf2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input longint aa, input longint bb,
                       input longint pc, input int md, input logic f);
    ce        = c;
    in_valid  = v;
    a         = aa[24:0];
    b         = bb[17:0];
    pci       = pc[47:0];
    pci2      = pc[43:0];
    mode      = md[1:0];
    acc_first = f;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (p !== 48'sd0) begin n_fail++; $display("FAIL reset_p: got %0d expected 0", p); end
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b expected 0", p_valid); end
    n_checks++; if (y !== 16'sd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    step();
    rst = 1'b0;
    // fill the pipeline with 5*5 products
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5, 5, 0, C_MUL, 1'b0);
      step();
    end
    n_checks++;
    if (p_valid !== 1'b1 || p !== 48'sd25) begin
      n_fail++; $display("FAIL fill_p: got valid=%b p=%0d expected valid=1 p=25", p_valid, p);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (p !== 48'sd0 || p_valid !== 1'b0 || y !== 16'sd0 || y_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midstream_reset: got p=%0d pv=%b y=%0d yv=%b ovf=%b expected all 0",
               p, p_valid, y, y_valid, ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 0, 0, 0, C_MUL, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (p_valid !== 1'b0 || y_valid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_valid[%0d]: got pv=%b yv=%b expected 0 0", i, p_valid, y_valid);
      end
    end
  endtask

  task automatic test_mul_madd_msub();
    longint t_a[6]   = '{-3, -3, -3, 0, 0, 1000};
    longint t_b[6]   = '{7, 7, 7, 0, 0, 1000};
    longint t_pci[6] = '{100, 100, 100, -196608, 0, 0};
    int     t_md[6]  = '{C_MUL, C_MADD, C_MSUB, C_MADD, C_MUL, C_MSUB};
    int     t_v[6]   = '{1, 1, 1, 1, 0, 1};
    longint t_p[6]   = '{-21, 79, 121, -196608, -196608, -1000000};
    int     t_y[6]   = '{0, 0, 0, -3, -3, -15};
    for (int i = 0; i < 6 + 5; i++) begin
      if (i < 6) drive(1'b1, t_v[i] != 0, t_a[i], t_b[i], t_pci[i], t_md[i], 1'b0);
      else       drive(1'b1, 1'b0, 0, 0, 0, C_MUL, 1'b0);
      step();
      if (i >= 3 && i < 6 + 3) begin
        n_checks++;
        if (p_valid !== (t_v[i-3] != 0) || p !== t_p[i-3]) begin
          n_fail++; $display("FAIL arith_p[%0d]: got valid=%b p=%0d expected valid=%0d p=%0d",
                             i-3, p_valid, p, t_v[i-3], t_p[i-3]);
        end
      end
      if (i >= 4 && i < 6 + 4) begin
        n_checks++;
        if (y_valid !== (t_v[i-4] != 0) || y !== t_y[i-4] || ovf !== 1'b0) begin
          n_fail++; $display("FAIL arith_y[%0d]: got valid=%b y=%0d ovf=%b expected valid=%0d y=%0d ovf=0",
                             i-4, y_valid, y, ovf, t_v[i-4], t_y[i-4]);
        end
      end
    end
  endtask

  task automatic test_acc_bubbles();
    longint t_a[7] = '{2, 0, 4, -1, 3, 10, 1};
    longint t_b[7] = '{3, 0, 5, 6, 3, 10, 1};
    int     t_md[7] = '{C_ACC, C_ACC, C_ACC, C_ACC, C_ACC, C_MUL, C_ACC};
    int     t_f[7] = '{1, 0, 0, 0, 1, 0, 0};
    int     t_v[7] = '{1, 0, 1, 1, 1, 1, 1};
    longint t_p[7] = '{6, 6, 26, 20, 9, 100, 101};
    for (int i = 0; i < 7 + 5; i++) begin
      if (i < 7) drive(1'b1, t_v[i] != 0, t_a[i], t_b[i], 0, t_md[i], t_f[i] != 0);
      else       drive(1'b1, 1'b0, 0, 0, 0, C_MUL, 1'b0);
      step();
      if (i >= 3 && i < 7 + 3) begin
        n_checks++;
        if (p_valid !== (t_v[i-3] != 0) || p !== t_p[i-3]) begin
          n_fail++; $display("FAIL acc_p[%0d]: got valid=%b p=%0d expected valid=%0d p=%0d",
                             i-3, p_valid, p, t_v[i-3], t_p[i-3]);
        end
      end
      if (i >= 4 && i < 7 + 4) begin
        n_checks++;
        if (y_valid !== (t_v[i-4] != 0) || y !== 16'sd0) begin
          n_fail++; $display("FAIL acc_y[%0d]: got valid=%b y=%0d expected valid=%0d y=0",
                             i-4, y_valid, y, t_v[i-4]);
        end
      end
    end
  endtask

  task automatic test_round_sat();
    longint t_a[9]   = '{128, 32767, 16777215, -16777216, -32769, 32767, 65535, -32768, 0};
    longint t_b[9]   = '{256, 1, 131071, 131071, 1, 65536, 32768, 65536, 0};
    longint t_pci[9] = '{0, 0, 0, 0, 0, 0, 0, 0, -64'sd2147516417};
    int     t_md[9]  = '{C_MUL, C_MUL, C_MUL, C_MUL, C_MUL, C_MUL, C_MUL, C_MUL, C_MADD};
    int     t_y[9]   = '{1, 0, 32767, -32768, -1, 32767, 32767, -32768, -32768};
    int     t_ovf[9] = '{0, 0, 1, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 9 + 5; i++) begin
      if (i < 9) drive(1'b1, 1'b1, t_a[i], t_b[i], t_pci[i], t_md[i], 1'b0);
      else       drive(1'b1, 1'b0, 0, 0, 0, C_MUL, 1'b0);
      step();
      if (i >= 4 && i < 9 + 4) begin
        n_checks++;
        if (y_valid !== 1'b1 || y !== t_y[i-4] || ovf !== (t_ovf[i-4] != 0)) begin
          n_fail++; $display("FAIL round_sat[%0d]: got valid=%b y=%0d ovf=%b expected valid=1 y=%0d ovf=%0d",
                             i-4, y_valid, y, ovf, t_y[i-4], t_ovf[i-4]);
        end
      end
    end
  endtask

  task automatic test_clock_enable();
    // expectations from cycle 4 onward, p in units of 65536
    int e_pv[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int e_p[11]  = '{2, 2, 2, 2, 3, 4, 5, 6, 7, 7, 7};
    int e_yv[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int e_y[11]  = '{1, 1, 1, 1, 2, 3, 4, 5, 6, 7, 7};
    for (int i = 0; i < 15; i++) begin
      if (i < 5)       drive(1'b1, 1'b1, i + 1, 65536, 0, C_MUL, 1'b0);
      else if (i < 8)  drive(1'b0, 1'b1, 99, 99, 0, C_MUL, 1'b0);
      else if (i < 10) drive(1'b1, 1'b1, i - 2, 65536, 0, C_MUL, 1'b0);
      else             drive(1'b1, 1'b0, 0, 0, 0, C_MUL, 1'b0);
      step();
      if (i >= 4) begin
        n_checks++;
        if (p_valid !== (e_pv[i-4] != 0) || p !== longint'(e_p[i-4]) * 65536 ||
            y_valid !== (e_yv[i-4] != 0) || y !== e_y[i-4]) begin
          n_fail++;
          $display("FAIL ce_freeze[cycle %0d]: got pv=%b p=%0d yv=%b y=%0d expected pv=%0d p=%0d yv=%0d y=%0d",
                   i, p_valid, p, y_valid, y, e_pv[i-4], longint'(e_p[i-4]) * 65536, e_yv[i-4], e_y[i-4]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    longint t_a[8] = '{-16777216, -16777216, -16777216, -16777216, 16777215, -16777216, 16777215, -16777216};
    longint t_b[8] = '{-131072, -131072, -131072, -131072, 131071, -131072, 131071, -131072};
    logic signed [43:0] e2[8];
    logic signed [43:0] acc_model;
    acc_model = '0;
    for (int k = 0; k < 8; k++) begin
      acc_model = (k == 0) ? 44'(t_a[k] * t_b[k]) : acc_model + 44'(t_a[k] * t_b[k]);
      e2[k] = acc_model;
    end
    for (int i = 0; i < 8 + 5; i++) begin
      if (i < 8) drive(1'b1, 1'b1, t_a[i], t_b[i], 0, C_ACC, i == 0);
      else       drive(1'b1, 1'b0, 0, 0, 0, C_MUL, 1'b0);
      step();
      if (i >= 3 && i < 8 + 3) begin
        n_checks++;
        if (p2_valid !== 1'b1 || p2 !== e2[i-3]) begin
          n_fail++; $display("FAIL wrap_p44[%0d]: got valid=%b p=%0h expected valid=1 p=%0h",
                             i-3, p2_valid, p2, e2[i-3]);
        end
        if (i == 6) begin
          // four products of 2^41 sum to 2^43, which is -2^43 in 44 bits
          n_checks++;
          if (p2 !== 44'sh800_0000_0000) begin
            n_fail++; $display("FAIL wrap_p44_hand: got %0h expected 80000000000", p2);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_madd_msub();
    test_acc_bubbles();
    test_round_sat();
    test_clock_enable();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
